// File: rtl/lcd_init_sequencer.sv
// lcd_init_sequencer: pulses the panel reset, plays a fixed init ROM of
// commands, data bytes and delays through spi_master, then hands the SPI
// link to a single host write port (valid/ready) for pixel/command streaming.
module lcd_init_sequencer #(
    parameter int RES_LOW_CYCLES  = 4,
    parameter int RES_WAIT_CYCLES = 30000,
    parameter int DELAY_UNIT      = 250,
    parameter int DONE_TIMEOUT    = 1024
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       spi_send,
    output logic [7:0] spi_data,
    input  logic       spi_done,
    output logic       lcd_dc,
    output logic       lcd_res,
    input  logic       wr_valid,
    input  logic       wr_dc,
    input  logic [7:0] wr_data,
    output logic       wr_ready,
    output logic       init_done,
    output logic       busy,
    output logic       error
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RES_LOW,
        S_RES_WAIT,
        S_FETCH,
        S_SEND,
        S_WAIT_DONE,
        S_DELAY,
        S_READY
    } state_t;

    localparam logic [1:0] T_CMD = 2'b00;
    localparam logic [1:0] T_DAT = 2'b01;
    localparam logic [1:0] T_DLY = 2'b10;
    localparam logic [1:0] T_END = 2'b11;

    // Counters are loaded with (length - 1) and leave their state on zero.
    localparam logic [31:0] RES_LOW_LOAD  = 32'(RES_LOW_CYCLES - 1);
    localparam logic [31:0] RES_WAIT_LOAD = 32'(RES_WAIT_CYCLES - 1);
    localparam logic [31:0] TIMEOUT_LOAD  = 32'(DONE_TIMEOUT - 1);
    localparam logic [31:0] DELAY_UNIT_W  = 32'(DELAY_UNIT);

    // Init ROM, {type[1:0], payload[7:0]}; every path ends in END.
    function automatic logic [9:0] rom_entry(input logic [3:0] idx);
        logic [9:0] e;
        case (idx)
            4'd0:    e = {T_CMD, 8'h01};  // software reset
            4'd1:    e = {T_DLY, 8'd5};
            4'd2:    e = {T_CMD, 8'h11};  // sleep out
            4'd3:    e = {T_DLY, 8'd5};
            4'd4:    e = {T_CMD, 8'h3A};  // pixel format
            4'd5:    e = {T_DAT, 8'h05};  // 16 bpp
            4'd6:    e = {T_CMD, 8'h29};  // display on
            default: e = {T_END, 8'h00};
        endcase
        return e;
    endfunction

    state_t      state_q, state_d;
    logic [3:0]  idx_q, idx_d;
    logic [31:0] cnt_q, cnt_d;
    logic        spi_send_q, spi_send_d;
    logic [7:0]  spi_data_q, spi_data_d;
    logic        lcd_dc_q, lcd_dc_d;
    logic        lcd_res_q, lcd_res_d;
    logic        init_done_q, init_done_d;
    logic        error_q, error_d;
    logic [9:0]  entry;
    logic [31:0] dly_len;

    assign entry   = rom_entry(idx_q);
    assign dly_len = 32'(entry[7:0]) * DELAY_UNIT_W;

    // Next-state and next-output logic for the whole sequencer.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        spi_send_d  = 1'b0;
        spi_data_d  = spi_data_q;
        lcd_dc_d    = lcd_dc_q;
        lcd_res_d   = lcd_res_q;
        init_done_d = init_done_q;
        error_d     = error_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d     = S_RES_LOW;
                    lcd_res_d   = 1'b0;
                    cnt_d       = RES_LOW_LOAD;
                    init_done_d = 1'b0;
                    error_d     = 1'b0;
                end
            end
            S_RES_LOW: begin
                if (cnt_q == '0) begin
                    state_d   = S_RES_WAIT;
                    lcd_res_d = 1'b1;
                    cnt_d     = RES_WAIT_LOAD;
                end else begin
                    cnt_d = cnt_q - 32'd1;
                end
            end
            S_RES_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = S_FETCH;
                    idx_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q - 32'd1;
                end
            end
            S_FETCH: begin
                case (entry[9:8])
                    T_CMD, T_DAT: begin
                        spi_data_d = entry[7:0];
                        lcd_dc_d   = entry[8];
                        spi_send_d = 1'b1;
                        state_d    = S_SEND;
                    end
                    T_DLY: begin
                        // Payload 0 still spends one cycle in DELAY.
                        cnt_d   = (entry[7:0] == 8'd0) ? 32'd0 : dly_len - 32'd1;
                        state_d = S_DELAY;
                    end
                    default: begin
                        init_done_d = 1'b1;
                        state_d     = S_READY;
                    end
                endcase
            end
            S_SEND: begin
                cnt_d   = TIMEOUT_LOAD;
                state_d = S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
                if (spi_done) begin
                    // init_done distinguishes host traffic from ROM traffic.
                    if (init_done_q) begin
                        state_d = S_READY;
                    end else begin
                        idx_d   = idx_q + 4'd1;
                        state_d = S_FETCH;
                    end
                end else if (cnt_q == '0) begin
                    error_d     = 1'b1;
                    init_done_d = 1'b0;
                    state_d     = S_IDLE;
                end else begin
                    cnt_d = cnt_q - 32'd1;
                end
            end
            S_DELAY: begin
                if (cnt_q == '0) begin
                    idx_d   = idx_q + 4'd1;
                    state_d = S_FETCH;
                end else begin
                    cnt_d = cnt_q - 32'd1;
                end
            end
            S_READY: begin
                // A restart request wins over a host byte offered in the same cycle.
                if (start) begin
                    state_d     = S_RES_LOW;
                    lcd_res_d   = 1'b0;
                    cnt_d       = RES_LOW_LOAD;
                    init_done_d = 1'b0;
                    error_d     = 1'b0;
                end else if (wr_valid) begin
                    spi_data_d = wr_data;
                    lcd_dc_d   = wr_dc;
                    spi_send_d = 1'b1;
                    state_d    = S_SEND;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and registered outputs, synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            idx_q       <= 4'd0;
            cnt_q       <= '0;
            spi_send_q  <= 1'b0;
            spi_data_q  <= 8'h00;
            lcd_dc_q    <= 1'b0;
            lcd_res_q   <= 1'b1;
            init_done_q <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            spi_send_q  <= spi_send_d;
            spi_data_q  <= spi_data_d;
            lcd_dc_q    <= lcd_dc_d;
            lcd_res_q   <= lcd_res_d;
            init_done_q <= init_done_d;
            error_q     <= error_d;
        end
    end

    assign spi_send  = spi_send_q;
    assign spi_data  = spi_data_q;
    assign lcd_dc    = lcd_dc_q;
    assign lcd_res   = lcd_res_q;
    assign init_done = init_done_q;
    assign error     = error_q;
    assign wr_ready  = (state_q == S_READY) && !start;
    assign busy      = (state_q != S_IDLE) && (state_q != S_READY);

endmodule

// File: tb/tb_lcd_init_sequencer.sv
// Testbench for lcd_init_sequencer: randomized SPI latency and host bytes,
// scoreboard of expected spi_send bytes/DC/cycle fed by a ROM-level model.
module tb_lcd_init_sequencer;

    localparam int RL = 4;
    localparam int RW = 10;
    localparam int DU = 3;
    localparam int DT = 20;
    localparam logic [7:0] WH_BYTE = 8'h11;

    logic       clk;
    logic       rst;
    logic       start;
    logic       spi_send;
    logic [7:0] spi_data;
    logic       spi_done;
    logic       lcd_dc;
    logic       lcd_res;
    logic       wr_valid;
    logic       wr_dc;
    logic [7:0] wr_data;
    logic       wr_ready;
    logic       init_done;
    logic       busy;
    logic       error;

    lcd_init_sequencer #(
        .RES_LOW_CYCLES (RL),
        .RES_WAIT_CYCLES(RW),
        .DELAY_UNIT     (DU),
        .DONE_TIMEOUT   (DT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .spi_send (spi_send),
        .spi_data (spi_data),
        .spi_done (spi_done),
        .lcd_dc   (lcd_dc),
        .lcd_res  (lcd_res),
        .wr_valid (wr_valid),
        .wr_dc    (wr_dc),
        .wr_data  (wr_data),
        .wr_ready (wr_ready),
        .init_done(init_done),
        .busy     (busy),
        .error    (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // cyc = number of rising edges so far; outputs are observed at the falling edge.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [7:0] b;
        logic       dc;
        int         t;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    int n_pass   = 0;
    int n_checks = 0;

    // Init ROM as documented: type 0=CMD 1=DAT 2=DLY 3=END.
    int rom_t [8] = '{0, 2, 0, 2, 0, 1, 0, 3};
    int rom_p [8] = '{8'h01, 5, 8'h11, 5, 8'h3A, 8'h05, 8'h29, 0};

    int cur_lat     = 5;
    bit withhold_en = 1'b0;
    bit stray_req   = 1'b0;

    task automatic check_i(input string name, input int act, input int expv);
        n_checks++;
        if (act == expv) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h) required %0d (0x%0h) at cycle %0d",
                      name, act, act, expv, expv, cyc);
    endtask

    task automatic check_b(input string name, input logic act, input logic expv);
        n_checks++;
        if (act === expv) n_pass++;
        else $display("FAIL %s: got %b required %b at cycle %0d", name, act, expv, cyc);
    endtask

    // Reference model: walk the ROM list and compute every expected send
    // (byte, DC, observation cycle) for a start sampled at edge n.
    function automatic void predict(input int n, input int lat, input bit wh,
                                    output int done_t, output int err_t, output int dly_t);
        int   t;
        exp_t e;
        t      = n + RL + RW;  // first FETCH
        done_t = -1;
        err_t  = -1;
        dly_t  = -1;
        for (int i = 0; i < 8; i++) begin
            if (rom_t[i] <= 1) begin
                e.b  = 8'(rom_p[i]);
                e.dc = (rom_t[i] == 1);
                e.t  = t + 1;
                exp_q.push_back(e);
                if (wh && (8'(rom_p[i]) == WH_BYTE)) begin
                    err_t = t + 1 + DT + 1;
                    return;
                end
                t = t + 1 + lat;
            end else if (rom_t[i] == 2) begin
                if (dly_t < 0) dly_t = t;
                t = t + ((rom_p[i] == 0) ? 1 : rom_p[i] * DU) + 1;
            end else begin
                done_t = t + 1;
                return;
            end
        end
    endfunction

    // spi_master model: spi_done sampled cur_lat edges after the send strobe.
    initial begin
        int done_cnt;
        done_cnt = 0;
        spi_done = 1'b0;
        forever begin
            @(negedge clk);
            spi_done = 1'b0;
            if (rst) done_cnt = 0;
            if (done_cnt > 0) begin
                done_cnt--;
                if (done_cnt == 0) spi_done = 1'b1;
            end
            if (stray_req) spi_done = 1'b1;
            if (!rst && spi_send && !(withhold_en && spi_data == WH_BYTE)) begin
                if (cur_lat <= 1) spi_done = 1'b1;
                else done_cnt = cur_lat - 1;
            end
        end
    end

    // Monitor: pop the scoreboard on every send strobe; wr_ready never high while busy.
    always @(negedge clk) begin
        if (!rst) begin
            if (busy) check_b("wr_ready_while_busy", wr_ready, 1'b0);
            if (spi_send) begin
                if (exp_q.size() == 0) begin
                    check_i("unexpected_send", int'(spi_data), -1);
                end else begin
                    mon_e = exp_q.pop_front();
                    check_i("send_byte", int'(spi_data), int'(mon_e.b));
                    check_b("send_dc", lcd_dc, mon_e.dc);
                    check_i("send_cycle", cyc, mon_e.t);
                end
            end
        end
    end

    task automatic run_init(input int lat, input bit stray, input bit wh,
                            input bit with_wr, input bit abort);
        int n, done_t, err_t, dly_t, low_cnt, k;
        cur_lat     = lat;
        withhold_en = wh;
        @(negedge clk);
        start = 1'b1;
        if (with_wr) begin
            wr_valid = 1'b1;
            wr_dc    = 1'b1;
            wr_data  = 8'hEE;
            #1;
            check_b("wr_ready_vs_start", wr_ready, 1'b0);
        end
        n = cyc + 1;
        predict(n, lat, wh, done_t, err_t, dly_t);
        @(negedge clk);
        start    = 1'b0;
        wr_valid = 1'b0;
        check_b("lcd_res_fall", lcd_res, 1'b0);
        check_b("init_done_cleared", init_done, 1'b0);
        check_b("error_cleared", error, 1'b0);
        check_b("busy_running", busy, 1'b1);
        low_cnt = 0;
        while (lcd_res == 1'b0 && low_cnt < 100) begin
            low_cnt++;
            @(negedge clk);
        end
        check_i("lcd_res_low_cycles", low_cnt, RL);
        if (abort) begin
            while (cyc < dly_t + 7) @(negedge clk);
            rst = 1'b1;
            @(negedge clk);
            check_b("abort_spi_send", spi_send, 1'b0);
            check_i("abort_spi_data", int'(spi_data), 0);
            check_b("abort_lcd_dc", lcd_dc, 1'b0);
            check_b("abort_lcd_res", lcd_res, 1'b1);
            check_b("abort_wr_ready", wr_ready, 1'b0);
            check_b("abort_init_done", init_done, 1'b0);
            check_b("abort_busy", busy, 1'b0);
            check_b("abort_error", error, 1'b0);
            rst = 1'b0;
            exp_q.delete();
            return;
        end
        if (stray) begin
            while (cyc < dly_t + 4) @(negedge clk);
            #1 stray_req = 1'b1;
            @(negedge clk);
            #1 stray_req = 1'b0;
        end
        k = 0;
        while (!init_done && !error && k < 2000) begin
            @(negedge clk);
            k++;
        end
        if (wh) begin
            check_i("timeout_cycle", cyc, err_t);
            check_b("timeout_error", error, 1'b1);
            check_b("timeout_init_done", init_done, 1'b0);
            check_b("timeout_idle", busy, 1'b0);
        end else begin
            check_i("init_done_cycle", cyc, done_t);
            check_b("ready_wr_ready", wr_ready, 1'b1);
            check_b("ready_not_busy", busy, 1'b0);
        end
    endtask

    task automatic host_write(input logic d, input logic [7:0] b, input int exp_k, output int k_out);
        int k;
        @(negedge clk);
        wr_valid = 1'b1;
        wr_dc    = d;
        wr_data  = b;
        k = 0;
        #1;
        while (!wr_ready && k < 200) begin
            @(negedge clk);
            #1;
            k++;
        end
        k_out = cyc + 1;
        if (!wr_ready) begin
            check_b("host_accept_timeout", wr_ready, 1'b1);
        end else begin
            exp_q.push_back('{b: b, dc: d, t: cyc + 1});
            if (exp_k >= 0) check_i("host_accept_cycle", cyc + 1, exp_k);
        end
        @(posedge clk);
    endtask

    task automatic host_seq(input bit fixed, input int n_rand);
        int k_prev, k;
        k_prev = -1;
        if (fixed) begin
            host_write(1'b1, 8'hAB, -1, k);
            k_prev = k;
            host_write(1'b0, 8'h2C, k_prev + cur_lat + 1, k);
            k_prev = k;
        end
        for (int i = 0; i < n_rand; i++) begin
            host_write(1'($urandom_range(1, 0)), 8'($urandom_range(255, 0)),
                       (k_prev < 0) ? -1 : k_prev + cur_lat + 1, k);
            k_prev = k;
        end
        @(negedge clk);
        wr_valid = 1'b0;
        k = 0;
        while (!wr_ready && k < 200) begin
            @(negedge clk);
            k++;
        end
        check_b("host_back_to_ready", wr_ready, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        wr_valid = 1'b0;
        wr_dc    = 1'b0;
        wr_data  = 8'h00;
        repeat (3) @(negedge clk);
        check_b("rst_spi_send", spi_send, 1'b0);
        check_i("rst_spi_data", int'(spi_data), 0);
        check_b("rst_lcd_dc", lcd_dc, 1'b0);
        check_b("rst_lcd_res", lcd_res, 1'b1);
        check_b("rst_wr_ready", wr_ready, 1'b0);
        check_b("rst_init_done", init_done, 1'b0);
        check_b("rst_busy", busy, 1'b0);
        check_b("rst_error", error, 1'b0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Nominal init with a 5-cycle SPI model, then host streaming.
        run_init(5, 1'b0, 1'b0, 1'b0, 1'b0);
        host_seq(1'b1, 3);

        // Re-run from READY with a stray spi_done during the first delay.
        run_init($urandom_range(8, 2), 1'b1, 1'b0, 1'b0, 1'b0);
        host_seq(1'b0, 3);

        // start and wr_valid together in READY.
        run_init($urandom_range(8, 2), 1'b0, 1'b0, 1'b1, 1'b0);
        host_seq(1'b0, 2);

        // spi_done withheld on 0x11: timeout, sticky error, then recovery.
        run_init($urandom_range(8, 2), 1'b0, 1'b1, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        check_b("error_sticky", error, 1'b1);
        check_b("error_idle_no_ready", wr_ready, 1'b0);
        run_init($urandom_range(8, 2), 1'b0, 1'b0, 1'b0, 1'b0);

        // Reset during DELAY, then a full restart from IDLE.
        run_init($urandom_range(8, 2), 1'b0, 1'b0, 1'b0, 1'b1);
        repeat (2) @(negedge clk);
        run_init($urandom_range(8, 2), 1'b0, 1'b0, 1'b0, 1'b0);
        host_seq(1'b0, 2);

        repeat (5) @(negedge clk);
        check_i("scoreboard_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
